timebase_compare_ctrl: RTL and testbench

TIMEBASE_COMPARE_CTRL -- requirements
Module: timebase_compare_ctrl

---
 rtl/timebase_compare_ctrl.sv | 116 +++++++++++
 tb/tb_timebase_compare_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/timebase_compare_ctrl.sv
// Timer timebase: edge/center-aligned 16-bit counter with preloaded ARR/CCR/OCM
// shadow registers, update-event generation and counter-vs-compare flags.
module timebase_compare_ctrl (
  input  logic        clk_i,
  input  logic        aresetn_i,
  input  logic        en_i,
  input  logic        cms_i,
  input  logic        dir_cfg_i,
  input  logic        arpe_i,
  input  logic        ocpe_i,
  input  logic        arr_wr_i,
  input  logic [15:0] arr_i,
  input  logic        ccr_wr_i,
  input  logic [15:0] ccr_i,
  input  logic        ocm_wr_i,
  input  logic [2:0]  ocm_i,
  input  logic        ug_i,
  output logic [15:0] cnt_o,
  output logic        dir_o,
  output logic [2:0]  ocm_o,
  output logic        cnt_equal_ccr_o,
  output logic        cnt_less_than_ccr_o,
  output logic        cnt_more_than_ccr_o,
  output logic        uev_o
);

  localparam logic [0:0] MODE_EDGE   = 1'b0;
  localparam logic [0:0] MODE_CENTER = 1'b1;

  logic [15:0] arr_pre, arr_act, arr_act_nx, arr_pre_nx;
  logic [15:0] ccr_pre, ccr_act, ccr_act_nx, ccr_pre_nx;
  logic [2:0]  ocm_pre, ocm_act, ocm_act_nx, ocm_pre_nx;
  logic [0:0]  mode_q, mode_nx;
  logic [15:0] cnt_nx;
  logic        dir_nx;
  logic        wrap;
  logic        uev;
  logic        restart;

  // Both modes wrap at the top while rising and at zero while falling.
  assign wrap    = dir_o ? (cnt_o == 16'd0) : (cnt_o == arr_act);
  assign uev     = (en_i & wrap) | ug_i;
  // Any update that is not a center-to-center turning point restarts the count.
  assign restart = ug_i | (uev & ~(cms_i & (mode_q == MODE_CENTER)));

  always_comb begin
    arr_pre_nx = arr_wr_i ? arr_i : arr_pre;
    ccr_pre_nx = ccr_wr_i ? ccr_i : ccr_pre;
    ocm_pre_nx = ocm_wr_i ? ocm_i : ocm_pre;

    arr_act_nx = arr_act;
    if (arr_wr_i && !arpe_i) arr_act_nx = arr_i;
    else if (uev)            arr_act_nx = arr_pre;

    ccr_act_nx = ccr_act;
    if (ccr_wr_i && !ocpe_i) ccr_act_nx = ccr_i;
    else if (uev)            ccr_act_nx = ccr_pre;

    ocm_act_nx = ocm_act;
    if (ocm_wr_i && !ocpe_i) ocm_act_nx = ocm_i;
    else if (uev)            ocm_act_nx = ocm_pre;
  end

  always_comb begin
    cnt_nx  = cnt_o;
    dir_nx  = dir_o;
    mode_nx = mode_q;
    if (restart) begin
      mode_nx = cms_i ? MODE_CENTER : MODE_EDGE;
      dir_nx  = cms_i ? 1'b0 : dir_cfg_i;
      cnt_nx  = (!cms_i && dir_cfg_i) ? arr_act_nx : 16'd0;
    end else if (uev) begin
      if (!dir_o) begin
        cnt_nx = (arr_act == 16'd0) ? 16'd0 : cnt_o - 16'd1;
        dir_nx = (arr_act != 16'd0);
      end else begin
        cnt_nx = (arr_act_nx == 16'd0) ? 16'd0 : 16'd1;
        dir_nx = 1'b0;
      end
    end else if (en_i) begin
      cnt_nx = dir_o ? cnt_o - 16'd1 : cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_o   <= 16'd0;
      dir_o   <= 1'b0;
      uev_o   <= 1'b0;
      mode_q  <= MODE_EDGE;
      arr_pre <= 16'hFFFF;
      arr_act <= 16'hFFFF;
      ccr_pre <= 16'd0;
      ccr_act <= 16'd0;
      ocm_pre <= 3'b000;
      ocm_act <= 3'b000;
    end else begin
      cnt_o   <= cnt_nx;
      dir_o   <= dir_nx;
      uev_o   <= uev;
      mode_q  <= mode_nx;
      arr_pre <= arr_pre_nx;
      arr_act <= arr_act_nx;
      ccr_pre <= ccr_pre_nx;
      ccr_act <= ccr_act_nx;
      ocm_pre <= ocm_pre_nx;
      ocm_act <= ocm_act_nx;
    end
  end

  assign ocm_o               = ocm_act;
  assign cnt_equal_ccr_o     = (cnt_o == ccr_act);
  assign cnt_less_than_ccr_o = (cnt_o <  ccr_act);
  assign cnt_more_than_ccr_o = (cnt_o >  ccr_act);

endmodule

// File: tb/tb_timebase_compare_ctrl.sv
// Bench for timebase_compare_ctrl: a cycle model checked every cycle plus
// directed scenarios with literal expectations.
module tb_timebase_compare_ctrl;

  logic        clk_i;
  logic        aresetn_i;
  logic        en_i, cms_i, dir_cfg_i, arpe_i, ocpe_i;
  logic        arr_wr_i, ccr_wr_i, ocm_wr_i, ug_i;
  logic [15:0] arr_i, ccr_i;
  logic [2:0]  ocm_i;
  logic [15:0] cnt_o;
  logic        dir_o, uev_o;
  logic [2:0]  ocm_o;
  logic        cnt_equal_ccr_o, cnt_less_than_ccr_o, cnt_more_than_ccr_o;

  int testCount = 0;
  int failCount = 0;

  timebase_compare_ctrl dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i), .en_i(en_i), .cms_i(cms_i),
    .dir_cfg_i(dir_cfg_i), .arpe_i(arpe_i), .ocpe_i(ocpe_i),
    .arr_wr_i(arr_wr_i), .arr_i(arr_i), .ccr_wr_i(ccr_wr_i), .ccr_i(ccr_i),
    .ocm_wr_i(ocm_wr_i), .ocm_i(ocm_i), .ug_i(ug_i),
    .cnt_o(cnt_o), .dir_o(dir_o), .ocm_o(ocm_o),
    .cnt_equal_ccr_o(cnt_equal_ccr_o), .cnt_less_than_ccr_o(cnt_less_than_ccr_o),
    .cnt_more_than_ccr_o(cnt_more_than_ccr_o), .uev_o(uev_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference model: state as the timer's programmer sees it.
  int m_cnt, m_arr_pre, m_arr_act, m_ccr_pre, m_ccr_act, m_ocm_pre, m_ocm_act;
  bit m_dir, m_center, m_uev;

  always @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      m_cnt = 0; m_dir = 0; m_center = 0; m_uev = 0;
      m_arr_pre = 65535; m_arr_act = 65535;
      m_ccr_pre = 0; m_ccr_act = 0; m_ocm_pre = 0; m_ocm_act = 0;
    end else begin
      bit atLimit, update;
      int newArr, newCcr, newOcm;
      atLimit = m_dir ? (m_cnt == 0) : (m_cnt == m_arr_act);
      update  = ug_i || (en_i && atLimit);
      newArr = (arr_wr_i && !arpe_i) ? int'(arr_i) : (update ? m_arr_pre : m_arr_act);
      newCcr = (ccr_wr_i && !ocpe_i) ? int'(ccr_i) : (update ? m_ccr_pre : m_ccr_act);
      newOcm = (ocm_wr_i && !ocpe_i) ? int'(ocm_i) : (update ? m_ocm_pre : m_ocm_act);
      if (ug_i || (update && !(m_center && cms_i))) begin
        m_center = cms_i;
        m_dir    = cms_i ? 1'b0 : dir_cfg_i;
        m_cnt    = (!cms_i && dir_cfg_i) ? newArr : 0;
      end else if (update) begin
        if (m_dir == 0) begin
          if (m_arr_act == 0) m_cnt = 0;
          else begin m_cnt = m_arr_act - 1; m_dir = 1; end
        end else begin
          m_cnt = (newArr == 0) ? 0 : 1;
          m_dir = 0;
        end
      end else if (en_i) begin
        m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
      end
      m_uev     = update;
      m_arr_act = newArr; m_ccr_act = newCcr; m_ocm_act = newOcm;
      if (arr_wr_i) m_arr_pre = arr_i;
      if (ccr_wr_i) m_ccr_pre = ccr_i;
      if (ocm_wr_i) m_ocm_pre = ocm_i;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk_i) begin
    checkOutput("m_cnt", int'(cnt_o), m_cnt);
    checkOutput("m_dir", int'(dir_o), int'(m_dir));
    checkOutput("m_uev", int'(uev_o), int'(m_uev));
    checkOutput("m_ocm", int'(ocm_o), m_ocm_act);
    checkOutput("m_eq",  int'(cnt_equal_ccr_o),     int'(m_cnt == m_ccr_act));
    checkOutput("m_lt",  int'(cnt_less_than_ccr_o), int'(m_cnt <  m_ccr_act));
    checkOutput("m_gt",  int'(cnt_more_than_ccr_o), int'(m_cnt >  m_ccr_act));
  end

  // One clock per step; write strobes and ug are single-cycle pulses.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk_i);
      #1;
      arr_wr_i = 0; ccr_wr_i = 0; ocm_wr_i = 0; ug_i = 0;
    end
  endtask

  int upSeq[5]     = '{1, 2, 3, 4, 0};
  int downSeq[4]   = '{2, 1, 0, 3};
  int centSeq[7]   = '{1, 2, 3, 2, 1, 0, 1};
  int centDir[7]   = '{0, 0, 0, 1, 1, 1, 0};
  int centUev[7]   = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    aresetn_i = 1; en_i = 0; cms_i = 0; dir_cfg_i = 0; arpe_i = 0; ocpe_i = 0;
    arr_wr_i = 0; arr_i = 0; ccr_wr_i = 0; ccr_i = 0; ocm_wr_i = 0; ocm_i = 0; ug_i = 0;
    #1 aresetn_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_cnt", int'(cnt_o), 0);
    checkOutput("rst_dir", int'(dir_o), 0);
    checkOutput("rst_uev", int'(uev_o), 0);
    checkOutput("rst_eq",  int'(cnt_equal_ccr_o), 1);
    @(negedge clk_i) aresetn_i = 1;

    // Edge up, arr=4
    arr_wr_i = 1; arr_i = 4; ug_i = 1; applyStimulus(1);
    checkOutput("ug_cnt", int'(cnt_o), 0);
    checkOutput("ug_uev", int'(uev_o), 1);
    en_i = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("up_cnt", int'(cnt_o), upSeq[i]);
      checkOutput("up_uev", int'(uev_o), (i == 4) ? 1 : 0);
    end

    // CCR preload behaviour, arr=9
    en_i = 0; arr_wr_i = 1; arr_i = 9; ccr_wr_i = 1; ccr_i = 2;
    ocm_wr_i = 1; ocm_i = 5; ug_i = 1; applyStimulus(1);
    checkOutput("ocm_direct", int'(ocm_o), 5);
    ocpe_i = 1; en_i = 1; applyStimulus(1);
    ccr_wr_i = 1; ccr_i = 5; applyStimulus(2);
    checkOutput("pre_cnt3", int'(cnt_o), 3);
    checkOutput("pre_gt_old", int'(cnt_more_than_ccr_o), 1);
    applyStimulus(7);
    checkOutput("pre_wrap_cnt", int'(cnt_o), 0);
    checkOutput("pre_wrap_uev", int'(uev_o), 1);
    applyStimulus(3);
    checkOutput("pre_lt_new", int'(cnt_less_than_ccr_o), 1);
    ocpe_i = 0; ccr_wr_i = 1; ccr_i = 3; applyStimulus(1);
    checkOutput("nopre_gt", int'(cnt_more_than_ccr_o), 1);

    // ug mid-count with a pending ARR preload
    arpe_i = 1; arr_wr_i = 1; arr_i = 12; applyStimulus(3);
    checkOutput("ug_at7", int'(cnt_o), 7);
    ug_i = 1; applyStimulus(1);
    checkOutput("ug7_cnt", int'(cnt_o), 0);
    checkOutput("ug7_uev", int'(uev_o), 1);
    applyStimulus(12);
    checkOutput("arr12_top", int'(cnt_o), 12);
    applyStimulus(1);
    checkOutput("arr12_wrap", int'(cnt_o), 0);
    applyStimulus(2);
    en_i = 0; ug_i = 1; applyStimulus(1);
    checkOutput("ug_dis_cnt", int'(cnt_o), 0);
    checkOutput("ug_dis_uev", int'(uev_o), 1);
    applyStimulus(1);
    checkOutput("dis_hold_uev", int'(uev_o), 0);

    // Edge down, arr=3
    arpe_i = 0; arr_wr_i = 1; arr_i = 3; dir_cfg_i = 1; ug_i = 1; applyStimulus(1);
    checkOutput("dn_start", int'(cnt_o), 3);
    en_i = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("dn_cnt", int'(cnt_o), downSeq[i]);
      checkOutput("dn_dir", int'(dir_o), 1);
      checkOutput("dn_uev", int'(uev_o), (i == 3) ? 1 : 0);
    end

    // Center, arr=3
    cms_i = 1; dir_cfg_i = 0; en_i = 0; ug_i = 1; applyStimulus(1);
    checkOutput("ctr_start", int'(cnt_o), 0);
    en_i = 1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1);
      checkOutput("ctr_cnt", int'(cnt_o), centSeq[i]);
      checkOutput("ctr_dir", int'(dir_o), centDir[i]);
      checkOutput("ctr_uev", int'(uev_o), centUev[i]);
    end

    // Center with arr=0
    arr_wr_i = 1; arr_i = 0; ug_i = 1; applyStimulus(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("z_cnt", int'(cnt_o), 0);
      checkOutput("z_dir", int'(dir_o), 0);
      checkOutput("z_uev", int'(uev_o), 1);
    end

    // CCR write coinciding with wrap, then async reset
    cms_i = 0; arr_wr_i = 1; arr_i = 4; ocpe_i = 0; ccr_wr_i = 1; ccr_i = 1; ug_i = 1;
    applyStimulus(1);
    ocpe_i = 1; ccr_wr_i = 1; ccr_i = 3; applyStimulus(1);
    applyStimulus(3);
    checkOutput("coinc_at4", int'(cnt_o), 4);
    ccr_wr_i = 1; ccr_i = 4; applyStimulus(1);
    checkOutput("coinc_uev", int'(uev_o), 1);
    applyStimulus(3);
    checkOutput("coinc_old_eq", int'(cnt_equal_ccr_o), 1);
    applyStimulus(6);
    checkOutput("coinc_new_eq", int'(cnt_equal_ccr_o), 1);
    applyStimulus(1);
    checkOutput("pre_rst_uev", int'(uev_o), 1);
    aresetn_i = 0;
    #1;
    checkOutput("arst_cnt", int'(cnt_o), 0);
    checkOutput("arst_uev", int'(uev_o), 0);
    checkOutput("arst_ocm", int'(ocm_o), 0);
    checkOutput("arst_eq",  int'(cnt_equal_ccr_o), 1);
    @(negedge clk_i) aresetn_i = 1;
    applyStimulus(1);
    checkOutput("post_rst_cnt", int'(cnt_o), 1);
    applyStimulus(1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
